// File: rtl/m_mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_mpu_pkg
// Description : Shared MPU datapath constants: beat modes and deserialiser
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package m_mpu_pkg;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILL    = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/m_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : m_out_slot
// Description : One-entry valid/ready holding register for a word plus count.
// Revision    : 1.0 - initial release
// ============================================================================
module m_out_slot #(
    parameter int WORD = 8,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WORD-1:0] load_line,
    input  logic [CNTW-1:0] load_cnt,
    input  logic            out_ready,
    output logic            free,
    output logic            out_valid,
    output logic [WORD-1:0] out_line,
    output logic [CNTW-1:0] out_cnt
);

    logic            r_valid;
    logic [WORD-1:0] r_line;
    logic [CNTW-1:0] r_cnt;

    assign free      = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_line  = r_line;
    assign out_cnt   = r_cnt;

    // Contents only change on load, so the word is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_line  <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_line  <= load_line;
            r_cnt   <= load_cnt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_demux_deser.sv
`default_nettype none
// ============================================================================
// Module      : m_demux_deser
// Description : Serial-to-parallel demultiplexer with sequential or addressed
//               bit placement and a one-word valid/ready output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module m_demux_deser
    import m_mpu_pkg::*;
#(
    parameter int WORD = 8,
    parameter int MUX  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_mode,
    input  logic [MUX-1:0]   in_sel,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_line,
    output logic [MUX:0]     out_cnt,
    output logic             err
);

    localparam int              CNTW       = MUX + 1;
    localparam logic [CNTW-1:0] c_cnt_max  = '1;
    localparam logic [CNTW-1:0] c_word     = CNTW'(WORD);
    localparam logic [MUX-1:0]  c_last_ptr = MUX'(WORD - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [WORD-1:0] r_asm;
    logic [WORD-1:0] w_asm_beat;
    logic [WORD-1:0] w_mask;
    logic [MUX-1:0]  r_ptr;
    logic [MUX-1:0]  w_idx;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_beat;
    logic            r_err;
    logic            w_accept;
    logic            w_complete;
    logic            w_bad_sel;
    logic            w_slot_free;
    logic            w_load;
    logic [WORD-1:0] w_load_line;
    logic [CNTW-1:0] w_load_cnt;

    assign in_ready   = (r_state != PENDING);
    assign err        = r_err;
    assign w_accept   = in_valid && in_ready;
    assign w_idx      = (in_mode == MODE_ADDR) ? in_sel : r_ptr;
    assign w_bad_sel  = (in_mode == MODE_ADDR) && ({1'b0, in_sel} >= c_word);
    // An out-of-range index shifts the single bit out entirely, dropping the write.
    assign w_mask     = WORD'(1) << w_idx;
    assign w_asm_beat = (r_asm & ~w_mask) | (in_bit ? w_mask : '0);
    assign w_cnt_beat = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNTW'(1);
    assign w_complete = in_last || ((in_mode == MODE_SEQ) && (r_ptr == c_last_ptr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_line  = w_asm_beat;
        w_load_cnt   = w_cnt_beat;
        case (r_state)
            EMPTY, FILL: begin
                if (w_accept) begin
                    if (!w_complete) begin
                        w_state_next = FILL;
                    end else if (w_slot_free) begin
                        w_load       = 1'b1;
                        w_state_next = EMPTY;
                    end else begin
                        w_state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                w_load_line = r_asm;
                w_load_cnt  = r_cnt;
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // A completing beat that cannot transfer leaves the finished word in r_asm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad_sel;
            if (w_load) begin
                r_asm <= '0;
                r_ptr <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_asm <= w_asm_beat;
                r_cnt <= w_cnt_beat;
                if ((in_mode == MODE_SEQ) && !w_complete) begin
                    r_ptr <= r_ptr + MUX'(1);
                end
            end
        end
    end

    m_out_slot #(
        .WORD (WORD),
        .CNTW (CNTW)
    ) u_out_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_line (w_load_line),
        .load_cnt  (w_load_cnt),
        .out_ready (out_ready),
        .free      (w_slot_free),
        .out_valid (out_valid),
        .out_line  (out_line),
        .out_cnt   (out_cnt)
    );

endmodule
`default_nettype wire

// File: doc/m_demux_deser.md
# m_demux_deser

Serial-to-parallel demultiplexer: the inverse of the team's bit-select mux. It accepts one bit per beat on a valid/ready input and steers each bit into a WORD-wide assembly register, either sequentially (auto-increment pointer) or at an explicit select index. It presents each completed word on a valid/ready output through a one-word output slot. It sits on the MPU datapath wherever a serial bit stream must be rebuilt into a parallel line feeding the mux side.

## Interface
- WORD, default 8: output word width; 2 ≤ WORD ≤ 2^MUX.
- MUX, default 3: select/pointer width.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat; a beat transfers when in_valid && in_ready.
- in_bit  in  1  data bit.
- in_mode  in  1  0 = sequential (write at internal pointer); 1 = addressed (write at in_sel).
- in_sel  in  MUX  bit index, used only when in_mode = 1.
- in_last  in  1  closes the current word with this beat.
- out_valid  out  1  out_line holds a completed word.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- out_line  out  WORD  completed word.
- out_cnt  out  MUX+1  number of beats accepted into out_line, 1..WORD in sequential mode; saturates at 2^(MUX+1)-1.
- err  out  1  one-cycle pulse: addressed beat with in_sel ≥ WORD.

## Operation
- State: assembly register asm (WORD), pointer ptr (MUX), beat counter cnt (MUX+1), pending flag, output slot (out_line, out_cnt, out_valid).
- in_ready = !pending (registered flag, no combinational path from out_ready).
- Sequential beat: asm[ptr] ← in_bit; ptr ← ptr+1. Completion when ptr == WORD-1 or in_last.
- Addressed beat: asm[in_sel] ← in_bit; ptr unchanged. Completion only on in_last. If in_sel ≥ WORD, the bit is dropped and err pulses next cycle. The beat still counts and can still complete.
- Modes may mix within one word. Bits never written in a word read 0. A later write to the same index overwrites the earlier one.
- Completion beat: the word includes that beat's bit.
  - Slot free (!out_valid || out_ready): load out_line/out_cnt and set out_valid. Clear asm, ptr and cnt to 0.
  - Otherwise: set pending and hold asm.
- Pending: when the slot frees, transfer, clear asm/ptr/cnt and clear pending. in_ready returns high the cycle after the transfer.
- out_valid drops when out_ready is taken and no transfer occurs in the same cycle. out_line is stable while out_valid && !out_ready.
- States: EMPTY (cnt = 0, !pending), FILL (cnt > 0), PENDING. Transitions: EMPTY→FILL on a non-completing beat. EMPTY/FILL→EMPTY on completion with the slot free. EMPTY/FILL→PENDING on completion with the slot busy. PENDING→EMPTY on slot free.

## Timing
- Reset (async assert, sync release): asm = 0, ptr = 0, cnt = 0, pending = 0, out_valid = 0, out_line = 0, out_cnt = 0, err = 0. in_ready = 1 from the first cycle after reset.
- Latency: a completion beat accepted at edge N with the slot free gives out_valid = 1 after edge N.
- Throughput: one bit per cycle sustained while out_ready is held high. No bubble between words.
- Simultaneous events: completion with out_valid && out_ready in the same cycle replaces the slot with no gap.
- Wrap: ptr wraps to 0 only through completion, never by overflow.
- Reset mid-word or mid-pending: the partial word and the pending word are discarded; no output follows.
- err is registered: it asserts exactly one cycle after the offending beat.

## Structure
- Shared package m_mpu_pkg: mode constants MODE_SEQ = 0 and MODE_ADDR = 1; state encoding EMPTY/FILL/PENDING.
- One natural sub-module, m_out_slot: a one-entry valid/ready holding register (WORD + MUX+1 bits) with a load and a free indication. It is reusable on other MPU outputs.

## Test plan
- Sequential, out_ready = 1: bits 1,0,1,1,0,0,1,0 (LSB first) -> out_line = 8'h4D, out_cnt = 8, out_valid high for 1 cycle, 1 cycle after the 8th beat.
- Addressed with in_last: sel 7 bit 1, sel 0 bit 1, sel 7 bit 0 + in_last -> out_line = 8'h01, out_cnt = 3.
- Early in_last in sequential mode after 3 beats of 1 -> out_line = 8'h07, out_cnt = 3; the next word starts at ptr 0.
- Back-pressure: out_ready = 0, stream 2 full words -> first word held in the slot, in_ready = 0 after the second completes. Raise out_ready -> words arrive in order, no loss, in_ready = 1 again.
- Error: WORD = 6, MUX = 3, addressed sel 6 -> err pulses 1 cycle, bit dropped, beat counted in out_cnt.
- Reset mid-word after 4 beats -> all outputs 0, in_ready = 1; the next 8 beats form a clean word.
